// File: rtl/fabric_port_arbiter_pkg.sv
// Shared OCP command/response encodings used by the fabric port arbiter and
// its neighbours on the port demux.
package fabric_port_arbiter_pkg;

    localparam logic [2:0] OCP_MCMD_IDLE = 3'b000;
    localparam logic [2:0] OCP_MCMD_WR   = 3'b001;
    localparam logic [2:0] OCP_MCMD_RD   = 3'b010;

    localparam logic [1:0] OCP_SRESP_NULL = 2'b00;
    localparam logic [1:0] OCP_SRESP_DVA  = 2'b01;
    localparam logic [1:0] OCP_SRESP_ERR  = 2'b11;

    // Any non-IDLE encoding, reserved ones included, counts as a request.
    function automatic logic ocp_is_req(input logic [2:0] cmd);
        return cmd != OCP_MCMD_IDLE;
    endfunction

endpackage

// File: rtl/fabric_port_arbiter.sv
// Two-master (instruction/data) arbiter for one OCP fabric port: parks on the
// last owner, holds the port from command issue to response, round-robins on contention.
module fabric_port_arbiter
    import fabric_port_arbiter_pkg::*;
#(
    parameter int WAIT_MAX  = 64,
    parameter int CNT_WIDTH = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] i_I_MCmd,
    input  logic [2:0] i_D_MCmd,
    input  logic       i_P_SCmdAccept,
    input  logic [1:0] i_P_SResp,
    output logic       o_select,
    output logic       o_busy,
    output logic       o_timeout
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMD  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic [CNT_WIDTH-1:0] LP_WAIT_LAST = CNT_WIDTH'((WAIT_MAX > 0) ? WAIT_MAX - 1 : 0);
    localparam logic [CNT_WIDTH-1:0] LP_WAIT_SAT  = '1;
    localparam logic                 LP_TMO_EN    = (WAIT_MAX != 0);

    state_t               r_state, w_state_nxt;
    logic                 r_select, w_select_nxt;
    logic                 r_timeout, w_timeout_nxt;
    logic [CNT_WIDTH-1:0] r_wait;

    logic w_sel_req, w_oth_req, w_resp, w_wait_last;

    assign w_sel_req   = ocp_is_req(r_select ? i_I_MCmd : i_D_MCmd);
    assign w_oth_req   = ocp_is_req(r_select ? i_D_MCmd : i_I_MCmd);
    assign w_resp      = (i_P_SResp != OCP_SRESP_NULL);
    assign w_wait_last = LP_TMO_EN && (r_wait == LP_WAIT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_select  <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_select  <= w_select_nxt;
            r_timeout <= w_timeout_nxt;
        end
    end

    // Held at zero outside RESP so every RESP entry starts counting from zero.
    always_ff @(posedge clk) begin
        if (rst || r_state != ST_RESP)
            r_wait <= '0;
        else if (LP_TMO_EN && !w_resp && r_wait != LP_WAIT_SAT)
            r_wait <= r_wait + 1'b1;
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_select_nxt  = r_select;
        w_timeout_nxt = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (w_sel_req) begin
                    w_state_nxt = i_P_SCmdAccept ? ST_RESP : ST_CMD;
                end else if (w_oth_req) begin
                    w_state_nxt  = ST_CMD;
                    w_select_nxt = ~r_select;
                end
            end
            ST_CMD: begin
                if (!w_sel_req)
                    w_state_nxt = ST_IDLE;
                else if (i_P_SCmdAccept)
                    w_state_nxt = ST_RESP;
            end
            ST_RESP: begin
                // A response arriving on the last wait cycle beats the timeout.
                if (w_resp) begin
                    if (w_oth_req) begin
                        w_state_nxt  = ST_CMD;
                        w_select_nxt = ~r_select;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end else if (w_wait_last) begin
                    w_state_nxt   = ST_IDLE;
                    w_timeout_nxt = 1'b1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign o_select  = r_select;
    assign o_busy    = (r_state != ST_IDLE);
    assign o_timeout = r_timeout;

endmodule

// File: tb/tb_fabric_port_arbiter.sv
// Bench for fabric_port_arbiter: one instance with a 4-cycle timeout, one with
// timeout disabled, both driven identically and compared against a transaction model.
module tb_fabric_port_arbiter;
    import fabric_port_arbiter_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] i_cmd, d_cmd;
    logic       acc;
    logic [1:0] rsp;
    logic       sel0, busy0, tmo0, sel1, busy1, tmo1;

    int tests = 0;
    int fails = 0;

    // Model: owner (1 = I), phase (0 free, 1 granted awaiting accept,
    // 2 awaiting response), response cycles waited so far, timeout pulse.
    int m_owner[2];
    int m_phase[2];
    int m_wait[2];
    bit m_tmo[2];

    always #5 clk = ~clk;

    fabric_port_arbiter #(.WAIT_MAX(4), .CNT_WIDTH(3)) dut0 (
        .clk(clk), .rst(rst), .i_I_MCmd(i_cmd), .i_D_MCmd(d_cmd),
        .i_P_SCmdAccept(acc), .i_P_SResp(rsp),
        .o_select(sel0), .o_busy(busy0), .o_timeout(tmo0));

    fabric_port_arbiter #(.WAIT_MAX(0), .CNT_WIDTH(2)) dut1 (
        .clk(clk), .rst(rst), .i_I_MCmd(i_cmd), .i_D_MCmd(d_cmd),
        .i_P_SCmdAccept(acc), .i_P_SResp(rsp),
        .o_select(sel1), .o_busy(busy1), .o_timeout(tmo1));

    task automatic chk(input string tag, input logic obs, input logic exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
        end
    endtask

    task automatic chki(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_step(input int k, input int wmax);
        bit mine, other, done;
        mine  = ((m_owner[k] == 1) ? i_cmd : d_cmd) != 3'd0;
        other = ((m_owner[k] == 1) ? d_cmd : i_cmd) != 3'd0;
        done  = (rsp != 2'd0);
        m_tmo[k] = 1'b0;
        if (rst) begin
            m_owner[k] = 0; m_phase[k] = 0; m_wait[k] = 0;
            return;
        end
        case (m_phase[k])
            0: if (mine) begin
                   m_phase[k] = acc ? 2 : 1;
                   m_wait[k]  = 0;
               end else if (other) begin
                   m_owner[k] = 1 - m_owner[k];
                   m_phase[k] = 1;
               end
            1: if (!mine) m_phase[k] = 0;
               else if (acc) begin
                   m_phase[k] = 2;
                   m_wait[k]  = 0;
               end
            default: if (done) begin
                   if (other) begin
                       m_owner[k] = 1 - m_owner[k];
                       m_phase[k] = 1;
                   end else begin
                       m_phase[k] = 0;
                   end
               end else if (wmax != 0 && m_wait[k] == wmax - 1) begin
                   m_phase[k] = 0;
                   m_tmo[k]   = 1'b1;
               end else begin
                   m_wait[k]++;
               end
        endcase
    endtask

    task automatic cyc(input logic [2:0] ic, input logic [2:0] dc, input logic a,
                       input logic [1:0] r, input logic rs);
        i_cmd = ic; d_cmd = dc; acc = a; rsp = r; rst = rs;
        @(posedge clk);
        model_step(0, 4);
        model_step(1, 0);
        #1;
        chk("sel0",  sel0,  m_owner[0] == 1);
        chk("busy0", busy0, m_phase[0] != 0);
        chk("tmo0",  tmo0,  m_tmo[0]);
        chk("sel1",  sel1,  m_owner[1] == 1);
        chk("busy1", busy1, m_phase[1] != 0);
        chk("tmo1",  tmo1,  m_tmo[1]);
    endtask

    initial begin
        int cnt, cnt1, at, toggles;
        logic prev;
        logic [2:0] ic, dc;
        logic [1:0] r;

        // Reset, then ten quiet cycles
        cyc(3'd0, 3'd0, 1'b0, 2'd0, 1'b1);
        cyc(3'd0, 3'd0, 1'b0, 2'd0, 1'b1);
        chk("rst_sel", sel0, 1'b0);
        chk("rst_busy", busy0, 1'b0);
        for (int i = 0; i < 10; i++) cyc(3'd0, 3'd0, 1'b0, 2'd0, 1'b0);

        // D read, immediate accept, DVA on the fourth RESP cycle (timeout boundary)
        cnt = 0;
        cyc(3'd0, OCP_MCMD_RD, 1'b1, 2'd0, 1'b0);
        cnt += busy0;
        for (int i = 0; i < 3; i++) begin
            cyc(3'd0, 3'd0, 1'b0, 2'd0, 1'b0);
            cnt += busy0;
        end
        cyc(3'd0, 3'd0, 1'b0, OCP_SRESP_DVA, 1'b0);
        cnt += busy0;
        chki("d_rd_busy_cycles", cnt, 4);
        chk("d_rd_no_tmo", tmo0, 1'b0);
        chk("d_rd_sel", sel0, 1'b0);

        // I read while parked on D: switch, two-cycle accept wait, DVA
        cyc(OCP_MCMD_RD, 3'd0, 1'b0, 2'd0, 1'b0);
        chk("i_rd_switch", sel0, 1'b1);
        cyc(OCP_MCMD_RD, 3'd0, 1'b0, 2'd0, 1'b0);
        cyc(OCP_MCMD_RD, 3'd0, 1'b1, 2'd0, 1'b0);
        cyc(3'd0, 3'd0, 1'b0, OCP_SRESP_ERR, 1'b0);
        chk("i_rd_park_sel", sel0, 1'b1);
        chk("i_rd_idle", busy0, 1'b0);

        // Both masters hammering: ownership must alternate
        toggles = 0;
        prev = sel0;
        for (int i = 0; i < 8; i++) begin
            cyc(OCP_MCMD_RD, OCP_MCMD_WR, 1'b1, OCP_SRESP_DVA, 1'b0);
            if (sel0 != prev) toggles++;
            prev = sel0;
        end
        chki("rr_toggles", toggles, 4);
        cyc(3'd0, 3'd0, 1'b0, 2'd0, 1'b0);

        // Timeout: D read accepted, no response
        cyc(3'd0, 3'd0, 1'b0, 2'd0, 1'b1);
        cyc(3'd0, OCP_MCMD_RD, 1'b1, 2'd0, 1'b0);
        cnt = 0; cnt1 = 0; at = -1;
        for (int i = 1; i <= 7; i++) begin
            cyc(3'd0, 3'd0, 1'b0, 2'd0, 1'b0);
            if (tmo0) begin cnt++; at = i; end
            cnt1 += tmo1;
        end
        chki("tmo_pulses", cnt, 1);
        chki("tmo_cycle", at, 4);
        chki("tmo_disabled", cnt1, 0);
        chk("tmo_idle", busy0, 1'b0);
        chk("tmo_disabled_busy", busy1, 1'b1);

        // Reset in RESP, then I read
        cyc(3'd0, 3'd0, 1'b0, 2'd0, 1'b1);
        cyc(3'd0, OCP_MCMD_RD, 1'b1, 2'd0, 1'b0);
        cyc(3'd0, 3'd0, 1'b0, 2'd0, 1'b0);
        cyc(OCP_MCMD_RD, 3'd0, 1'b0, 2'd0, 1'b1);
        chk("rst_resp_sel", sel0, 1'b0);
        chk("rst_resp_busy", busy0, 1'b0);
        chk("rst_resp_tmo", tmo0, 1'b0);
        cyc(OCP_MCMD_RD, 3'd0, 1'b0, 2'd0, 1'b0);
        chk("post_rst_switch", sel0, 1'b1);
        cyc(3'd0, 3'd0, 1'b0, 2'd0, 1'b0);

        // Random traffic, reserved command encodings included
        for (int i = 0; i < 3000; i++) begin
            ic = ($urandom_range(0, 2) == 0) ? 3'd0 : 3'($urandom_range(1, 7));
            dc = ($urandom_range(0, 2) == 0) ? 3'd0 : 3'($urandom_range(1, 7));
            r  = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
            cyc(ic, dc, 1'($urandom_range(0, 1)), r, $urandom_range(0, 99) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
